alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the team's 16-bit combinational arithmetic/logic blocks.
- Ops: add, sub, mul, div, and, nand, shift-left, shift-right behind one opcode port.
- Registered result; divide is iterative, multi-cycle (no `/` operator); other ops single-cycle.
- Sits between the operand register file and writeback; valid/ready on both sides.

Parameters:
- WIDTH, 16, operand/result width in bits (≥4).
- OPW, 3, opcode width (fixed at 3; 8 ops).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  block can accept a command this cycle
- op  in  OPW  0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 NAND, 6 SHL, 7 SHR
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B; shift amount for SHL/SHR
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  result
- carry  out  1  ADD carry-out; SUB borrow (a<b unsigned); MUL: upper product half nonzero; else 0
- zero  out  1  result == 0
- div0  out  1  DIV with b==0

Behaviour:
- Reset (sync, rst=1 at clk edge): state IDLE; out_valid=0, result=0, carry=0, zero=0, div0=0; any division in progress is aborted and discarded.
- in_ready = (state==IDLE) && (!out_valid || out_ready). A command is accepted when in_valid && in_ready.
- A command accepted in the same cycle as the output is taken is legal; the new result replaces the old one with no bubble.
- FSM states: IDLE, DIV.
  - IDLE, accept non-DIV: result and flags registered at the next edge; out_valid=1. Latency 1.
  - IDLE, accept DIV with b!=0: latch a and b, clear the remainder, count=WIDTH, go to DIV.
  - IDLE, accept DIV with b==0: single-cycle result = all ones, div0=1, carry=0. Stay in IDLE.
  - DIV: one restoring step per cycle, MSB first: shift the remainder left with the next dividend bit and subtract b if it fits, setting the quotient bit.
  - DIV exit: after WIDTH steps, result = quotient and out_valid=1; return to IDLE. Latency WIDTH+1 from accept. in_ready=0 throughout DIV.
- Output hold: while out_valid && !out_ready, result and flags hold stable.
- Output drop: when out_valid && out_ready and no new accept, out_valid falls at the next edge.
- Arithmetic, all unsigned:
  - ADD/SUB are WIDTH+1 internally; result is the low WIDTH bits.
  - MUL: result = low WIDTH bits of the 2*WIDTH product.
  - SHL/SHR are logical. If b ≥ WIDTH, result = 0.
  - zero is computed on the registered result for every op.
- Unknown ops: none (3-bit op fully decoded).

Optional Feature:
- Macro ALU_SEQ_DIVREM_EN.
- Defined: extra output port rem (WIDTH). It carries the DIV remainder and is valid with out_valid. It equals a on divide-by-zero and is 0 for non-DIV ops. It resets to 0.
- Undefined: no rem port, and the remainder register is trimmed to what the divider needs internally. All other behaviour is identical.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode localparams OP_ADD..OP_SHR;
  - state encodings ST_IDLE and ST_DIV.
- Sub-module alu_seq_div:
  - iterative restoring divider with start/busy/done;
  - ports: quotient, remainder, div0;
  - parametrised by WIDTH.
- alu_seq instantiates it and muxes its results with the single-cycle datapath.

Test Plan:
1. WIDTH=16: ADD a=0xFFFF, b=0x0001 -> next cycle result=0x0000, carry=1, zero=1, out_valid=1.
2. DIV a=100, b=7 -> in_ready low for 16 cycles; result=14 on cycle 17; rem=2 with ALU_SEQ_DIVREM_EN; div0=0.
3. DIV a=0x1234, b=0 -> after 1 cycle: result=0xFFFF, div0=1, rem=0x1234 with the macro defined.
4. SHL a=11, b=5 -> 0x0160; then SHL a=0x0160, b=2 -> 0x0580; SHR a=0x8000, b=16 -> 0x0000, zero=1.
5. MUL a=0x0100, b=0x0100 with out_ready=0 for 3 cycles -> result=0x0000 and carry=1 held stable, in_ready=0; on out_ready=1, out_valid drops the next cycle.
6. Assert rst on cycle 5 of DIV 0xFFFF/3 -> next cycle state IDLE, out_valid=0, result=0; a following AND 0xFFFF & 0x0F0F yields 0x0F0F, and NAND yields 0xF0F0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// +----------------------------------------------------------------------+
// | Module   : alu_seq_pkg                                                |
// | Purpose  : Opcode and FSM state encodings shared by the alu_seq       |
// |            datapath, its iterative divider and their users.           |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

package alu_seq_pkg;

   // Opcode map, fully decoded over 3 bits
   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_MUL  = 3'd2;
   localparam logic [2:0] OP_DIV  = 3'd3;
   localparam logic [2:0] OP_AND  = 3'd4;
   localparam logic [2:0] OP_NAND = 3'd5;
   localparam logic [2:0] OP_SHL  = 3'd6;
   localparam logic [2:0] OP_SHR  = 3'd7;

   // Top-level controller states
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_DIV  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/alu_seq_div.sv
// +----------------------------------------------------------------------+
// | Module   : alu_seq_div                                                |
// | Purpose  : Iterative restoring divider, one quotient bit per cycle,   |
// |            MSB first. Quotient/remainder are presented on the cycle   |
// |            o_done is high so the parent can register them directly.   |
// | Config   : ALU_SEQ_DIVREM_EN exposes the remainder on o_remainder.    |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module alu_seq_div
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 16
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_quotient,
`ifdef ALU_SEQ_DIVREM_EN
   output logic [WIDTH-1:0] o_remainder,
`endif
   output logic             o_div0
);

   localparam int                 c_cnt_w = $clog2(WIDTH + 1);
   localparam logic [c_cnt_w-1:0] c_steps = c_cnt_w'(WIDTH);
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(1);

   logic               r_busy;
   logic [c_cnt_w-1:0] r_count;
   logic [WIDTH-1:0]   r_dvd;     // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0]   r_rem;     // partial remainder
   logic [WIDTH-1:0]   r_dvs;     // latched divisor

   logic [WIDTH:0]     w_trial;
   logic               w_fits;
   logic [WIDTH-1:0]   w_sub;
   logic [WIDTH-1:0]   w_rem_next;
   logic [WIDTH-1:0]   w_q_next;

   // One restoring step: bring in the next dividend bit and subtract if it fits.
   // When it fits the true difference is below the divisor, so a WIDTH-bit
   // subtraction is exact.
   always_comb begin
      w_trial    = {r_rem, r_dvd[WIDTH-1]};
      w_fits     = (w_trial >= {1'b0, r_dvs});
      w_sub      = w_trial[WIDTH-1:0] - r_dvs;
      w_rem_next = w_fits ? w_sub : w_trial[WIDTH-1:0];
      w_q_next   = {r_dvd[WIDTH-2:0], w_fits};
   end

   // Step sequencer: a start with a zero divisor is ignored, the parent handles it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy  <= 1'b0;
         r_count <= '0;
         r_dvd   <= '0;
         r_rem   <= '0;
         r_dvs   <= '0;
      end else if (!r_busy) begin
         if (i_start && !o_div0) begin
            r_busy  <= 1'b1;
            r_count <= c_steps;
            r_dvd   <= i_dividend;
            r_rem   <= '0;
            r_dvs   <= i_divisor;
         end
      end else begin
         r_dvd   <= w_q_next;
         r_rem   <= w_rem_next;
         r_count <= r_count - c_last;
         if (r_count == c_last) begin
            r_busy <= 1'b0;
         end
      end
   end

   assign o_busy      = r_busy;
   assign o_done      = r_busy && (r_count == c_last);
   assign o_quotient  = w_q_next;
`ifdef ALU_SEQ_DIVREM_EN
   assign o_remainder = w_rem_next;
`endif
   assign o_div0      = (i_divisor == '0);

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// +----------------------------------------------------------------------+
// | Module   : alu_seq                                                    |
// | Purpose  : Handshaked arithmetic/logic unit. ADD/SUB/MUL/AND/NAND/    |
// |            SHL/SHR complete in one cycle; DIV runs WIDTH cycles on    |
// |            alu_seq_div. Result and flags are registered.              |
// | Config   : ALU_SEQ_DIVREM_EN adds the 'rem' output (DIV remainder).   |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int OPW   = 3
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OPW-1:0]   op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
`ifdef ALU_SEQ_DIVREM_EN
   output logic [WIDTH-1:0] rem,
`endif
   output logic             div0
);

   localparam logic [WIDTH-1:0] c_width = WIDTH'(WIDTH);

   logic [0:0]         r_state;
   logic               r_out_valid;
   logic [WIDTH-1:0]   r_result;
   logic               r_carry;
   logic               r_zero;
   logic               r_div0;
`ifdef ALU_SEQ_DIVREM_EN
   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   w_rem;
   logic [WIDTH-1:0]   w_div_rem;
`endif

   logic               w_accept;
   logic               w_is_div;
   logic               w_b_zero;
   logic               w_div_busy;
   logic               w_div_done;
   logic [WIDTH-1:0]   w_quot;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_diff;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_res;
   logic               w_carry;
   logic               w_div0;

   assign in_ready = (r_state == ST_IDLE) && !w_div_busy && (!r_out_valid || out_ready);
   assign w_accept = in_valid && in_ready;
   assign w_is_div = (op == OP_DIV);

   alu_seq_div #(
      .WIDTH       (WIDTH)
   ) u_div (
      .clk         (clk),
      .rst         (rst),
      .i_start     (w_accept && w_is_div),
      .i_dividend  (a),
      .i_divisor   (b),
      .o_busy      (w_div_busy),
      .o_done      (w_div_done),
      .o_quotient  (w_quot),
`ifdef ALU_SEQ_DIVREM_EN
      .o_remainder (w_div_rem),
`endif
      .o_div0      (w_b_zero)
   );

   assign w_sum  = {1'b0, a} + {1'b0, b};
   assign w_diff = {1'b0, a} - {1'b0, b};
   assign w_prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

   // Single-cycle datapath; the DIV arm is only used for the divide-by-zero case.
   always_comb begin
      w_res   = '0;
      w_carry = 1'b0;
      w_div0  = 1'b0;
`ifdef ALU_SEQ_DIVREM_EN
      w_rem   = '0;
`endif
      case (op)
         OP_ADD: begin
            w_res   = w_sum[WIDTH-1:0];
            w_carry = w_sum[WIDTH];
         end
         OP_SUB: begin
            w_res   = w_diff[WIDTH-1:0];
            w_carry = w_diff[WIDTH];
         end
         OP_MUL: begin
            w_res   = w_prod[WIDTH-1:0];
            w_carry = |w_prod[2*WIDTH-1:WIDTH];
         end
         OP_DIV: begin
            w_res   = '1;
            w_div0  = 1'b1;
`ifdef ALU_SEQ_DIVREM_EN
            w_rem   = a;
`endif
         end
         OP_AND:  w_res = a & b;
         OP_NAND: w_res = ~(a & b);
         OP_SHL:  w_res = (b >= c_width) ? '0 : (a << b);
         OP_SHR:  w_res = (b >= c_width) ? '0 : (a >> b);
         default: w_res = '0;
      endcase
   end

   // Controller and output register: accept, divide wait, hold and drop.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_carry     <= 1'b0;
         r_zero      <= 1'b0;
         r_div0      <= 1'b0;
`ifdef ALU_SEQ_DIVREM_EN
         r_rem       <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  if (w_is_div && !w_b_zero) begin
                     r_state     <= ST_DIV;
                     r_out_valid <= 1'b0;
                  end else begin
                     r_out_valid <= 1'b1;
                     r_result    <= w_res;
                     r_carry     <= w_carry;
                     r_zero      <= (w_res == '0);
                     r_div0      <= w_div0;
`ifdef ALU_SEQ_DIVREM_EN
                     r_rem       <= w_rem;
`endif
                  end
               end else if (out_ready) begin
                  r_out_valid <= 1'b0;
               end
            end
            ST_DIV: begin
               if (w_div_done) begin
                  r_state     <= ST_IDLE;
                  r_out_valid <= 1'b1;
                  r_result    <= w_quot;
                  r_carry     <= 1'b0;
                  r_zero      <= (w_quot == '0);
                  r_div0      <= 1'b0;
`ifdef ALU_SEQ_DIVREM_EN
                  r_rem       <= w_div_rem;
`endif
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign carry     = r_carry;
   assign zero      = r_zero;
   assign div0      = r_div0;
`ifdef ALU_SEQ_DIVREM_EN
   assign rem       = r_rem;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// +----------------------------------------------------------------------+
// | Module   : tb_alu_seq                                                 |
// | Purpose  : Self-checking bench for alu_seq (WIDTH=16): directed       |
// |            literal cases plus randomized traffic against a            |
// |            transaction-level reference model.                         |
// | Config   : honours ALU_SEQ_DIVREM_EN (checks 'rem' when defined).     |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_alu_seq;

   localparam int W = 16;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    op;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  result;
   logic          carry;
   logic          zero;
   logic          div0;
`ifdef ALU_SEQ_DIVREM_EN
   logic [W-1:0]  rem;
`endif

   int checks   = 0;
   int failures = 0;

   alu_seq #(.WIDTH(W), .OPW(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry     (carry),
      .zero      (zero),
`ifdef ALU_SEQ_DIVREM_EN
      .rem       (rem),
`endif
      .div0      (div0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic straight from the operation definitions.
   task automatic model_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                           output logic [W-1:0] res, output logic cy, output logic dz,
                           output logic [W-1:0] rm);
      int unsigned    xi = x;
      int unsigned    yi = y;
      longint unsigned p;
      res = '0; cy = 1'b0; dz = 1'b0; rm = '0;
      case (o)
         3'd0: begin res = W'((xi + yi) & 32'hFFFF); cy = ((xi + yi) > 32'hFFFF); end
         3'd1: begin res = W'((xi - yi) & 32'hFFFF); cy = (xi < yi); end
         3'd2: begin p = longint'(xi) * longint'(yi); res = W'(p & 64'hFFFF); cy = ((p >> 16) != 0); end
         3'd3: begin
            if (yi == 0) begin res = 16'hFFFF; dz = 1'b1; rm = x; end
            else begin res = W'(xi / yi); rm = W'(xi % yi); end
         end
         3'd4: res = x & y;
         3'd5: res = ~(x & y);
         3'd6: res = (yi >= W) ? '0 : W'((xi << yi) & 32'hFFFF);
         default: res = (yi >= W) ? '0 : W'(xi >> yi);
      endcase
   endtask

   // Model state: what the outputs must show after the next clock edge.
   logic         m_known = 1'b0;
   logic         m_valid;
   logic [W-1:0] m_res;
   logic         m_carry;
   logic         m_zero;
   logic         m_div0;
   logic [W-1:0] m_rem;
   int           m_busy;
   logic [W-1:0] m_pq;
   logic [W-1:0] m_pr;

   // Compare the DUT against the model mid-cycle, then advance the model.
   always @(negedge clk) begin
      logic         exp_ready;
      logic [W-1:0] t_res;
      logic         t_cy;
      logic         t_dz;
      logic [W-1:0] t_rm;
      if (m_known) begin
         exp_ready = (m_busy == 0) && (!m_valid || out_ready);
         chk("model_in_ready", in_ready, exp_ready);
         chk("model_out_valid", out_valid, m_valid);
         if (m_valid) begin
            chk("model_result", result, m_res);
            chk("model_flags", {carry, zero, div0}, {m_carry, m_zero, m_div0});
`ifdef ALU_SEQ_DIVREM_EN
            chk("model_rem", rem, m_rem);
`endif
         end
      end
      if (rst) begin
         m_known = 1'b1;
         m_valid = 1'b0; m_res = '0; m_carry = 1'b0; m_zero = 1'b0;
         m_div0 = 1'b0; m_rem = '0; m_busy = 0; m_pq = '0; m_pr = '0;
      end else if (m_known) begin
         exp_ready = (m_busy == 0) && (!m_valid || out_ready);
         if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
               m_valid = 1'b1; m_res = m_pq; m_rem = m_pr;
               m_carry = 1'b0; m_div0 = 1'b0; m_zero = (m_pq == 0);
            end
         end else if (in_valid && exp_ready) begin
            model_op(op, a, b, t_res, t_cy, t_dz, t_rm);
            if (op == 3'd3 && b != 0) begin
               m_busy = W; m_valid = 1'b0; m_pq = t_res; m_pr = t_rm;
            end else begin
               m_valid = 1'b1; m_res = t_res; m_carry = t_cy; m_div0 = t_dz;
               m_rem = t_rm; m_zero = (t_res == 0);
            end
         end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   // Present a command and hold it until it is taken (bounded).
   task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      int n = 0;
      @(posedge clk); #1;
      op = o; a = x; b = y; in_valid = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 100);
      if (!in_ready) chk("send_accept_timeout", 1'b0, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Wait for out_valid (bounded), counting cycles with in_ready low.
   task automatic wait_out(output int low);
      int n = 0;
      low = 0;
      @(negedge clk);
      while (!out_valid && n < 200) begin
         if (!in_ready) low++;
         n++;
         @(negedge clk);
      end
      chk("out_valid_seen", out_valid, 1'b1);
   endtask

   initial begin
      int low;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_result", result, 16'h0000);
      chk("reset_flags", {carry, zero, div0}, 3'b000);
      chk("reset_in_ready", in_ready, 1'b1);

      send(3'd0, 16'hFFFF, 16'h0001);
      wait_out(low);
      chk("add_result", result, 16'h0000);
      chk("add_carry_zero", {carry, zero}, 2'b11);

      send(3'd3, 16'd100, 16'd7);
      wait_out(low);
      chk("div_busy_cycles", low, 16);
      chk("div_result", result, 16'd14);
      chk("div_div0", div0, 1'b0);
`ifdef ALU_SEQ_DIVREM_EN
      chk("div_rem", rem, 16'd2);
`endif

      send(3'd3, 16'h1234, 16'h0000);
      wait_out(low);
      chk("div0_latency", low, 0);
      chk("div0_result", result, 16'hFFFF);
      chk("div0_flags", {carry, div0}, 2'b01);
`ifdef ALU_SEQ_DIVREM_EN
      chk("div0_rem", rem, 16'h1234);
`endif

      send(3'd6, 16'd11, 16'd5);
      wait_out(low);
      chk("shl5_result", result, 16'h0160);
      send(3'd6, 16'h0160, 16'd2);
      wait_out(low);
      chk("shl2_result", result, 16'h0580);
      send(3'd7, 16'h8000, 16'd16);
      wait_out(low);
      chk("shr16_result", result, 16'h0000);
      chk("shr16_zero", zero, 1'b1);

      send(3'd2, 16'h0100, 16'h0100);
      out_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("mul_hold_valid", out_valid, 1'b1);
         chk("mul_hold_result", result, 16'h0000);
         chk("mul_hold_carry", carry, 1'b1);
         chk("mul_hold_in_ready", in_ready, 1'b0);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk);
      chk("mul_taken_valid", out_valid, 1'b1);
      @(negedge clk);
      chk("mul_dropped_valid", out_valid, 1'b0);

      send(3'd3, 16'hFFFF, 16'd3);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_div_out_valid", out_valid, 1'b0);
      chk("rst_div_result", result, 16'h0000);
      chk("rst_div_in_ready", in_ready, 1'b1);
      send(3'd4, 16'hFFFF, 16'h0F0F);
      wait_out(low);
      chk("and_result", result, 16'h0F0F);
      send(3'd5, 16'hFFFF, 16'h0F0F);
      wait_out(low);
      chk("nand_result", result, 16'hF0F0);

      for (int i = 0; i < 4000; i++) begin
         @(posedge clk); #1;
         rst       = ($urandom_range(0, 299) == 0);
         in_valid  = ($urandom_range(0, 1) == 1);
         out_ready = ($urandom_range(0, 9) < 7);
         op        = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0:       a = 16'hFFFF;
            1:       a = 16'($urandom_range(0, 15));
            default: a = 16'($urandom);
         endcase
         case ($urandom_range(0, 4))
            0:       b = 16'h0000;
            1:       b = 16'($urandom_range(0, 20));
            2:       b = 16'hFFFF;
            default: b = 16'($urandom);
         endcase
      end
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (40) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
